// File: rtl/single_port_blockram_requester.sv
// Initiator-side controller for one single_port_blockram: zero-fills the RAM after reset,
// then forwards read/write requests and returns read data in order through a credited FIFO.

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module single_port_blockram_requester #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int READ_LATENCY              = 1,
    parameter int RESP_FIFO_DEPTH           = 2
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_done_out,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic                                 request_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
    input  logic [WRITE_MASK_LEN-1:0]            request_mask_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     response_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
    output logic                                 ram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in
);

    localparam int FIFO_PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(RESP_FIFO_DEPTH + READ_LATENCY + 1) + 1;

    typedef enum logic {
        INIT,
        ACTIVE
    } state_t;

    state_t state;
    state_t next_state;

    logic [SET_PTR_WIDTH_IN_BITS-1:0]     init_cnt;
    logic                                 init_last;

    logic [READ_LATENCY-1:0]              pipe_valid;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     pipe_addr [READ_LATENCY];

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] fifo_data [RESP_FIFO_DEPTH];
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     fifo_addr [RESP_FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]                wr_ptr;
    logic [FIFO_PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                     fifo_count;
    logic [CNT_W-1:0]                     inflight_reads;

    logic fire;
    logic accept_read;
    logic push;
    logic pop;

    assign init_last   = (init_cnt == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1));
    assign fire        = request_valid_in && request_ready_out;
    assign accept_read = fire && !request_write_in;
    assign push        = pipe_valid[READ_LATENCY-1];
    assign pop         = response_valid_out && response_ready_in;

    assign init_done_out      = (state == ACTIVE);
    assign response_valid_out = (fifo_count != '0);
    assign response_addr_out  = fifo_addr[rd_ptr];
    assign response_data_out  = fifo_data[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == INIT && init_last) begin
            next_state = ACTIVE;
        end
    end

    // Sweep counter holds at its last value rather than wrapping once ACTIVE is reached.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            init_cnt <= '0;
        end else if (state == INIT && !init_last) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        inflight_reads = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_reads = inflight_reads + CNT_W'(pipe_valid[i]);
        end
    end

    // Every accepted request consumes a credit check so a read can never find the FIFO full.
    assign request_ready_out = (state == ACTIVE) &&
                               ((fifo_count + inflight_reads) < CNT_W'(RESP_FIFO_DEPTH));

    always_comb begin
        ram_access_en_out   = 1'b0;
        ram_write_en_out    = '0;
        ram_set_addr_out    = request_addr_in;
        ram_write_entry_out = request_data_in;
        if (state == INIT) begin
            ram_access_en_out   = 1'b1;
            ram_write_en_out    = '1;
            ram_set_addr_out    = init_cnt;
            ram_write_entry_out = '0;
        end else begin
            ram_access_en_out = fire;
            if (fire && request_write_in) begin
                ram_write_en_out = request_mask_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept_read;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        pipe_addr[0] <= request_addr_in;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_read_entry_in;
            fifo_addr[wr_ptr] <= pipe_addr[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
